// File: rtl/ddr_burst_pkg.sv
// rtl/ddr_burst_pkg.sv - shared types, constants and beat-index helper for the burst responder
package ddr_burst_pkg;

  localparam int BURST_LEN_W        = 10;
  localparam int ADDR_STEP_LOG2_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    WR_LAST,
    RD_WAIT,
    RD_BEAT,
    DONE_WR,
    DONE_RD
  } burst_state_e;

  // RAM index of beat cnt of a burst starting at addr; wraps modulo the RAM depth.
  function automatic logic [31:0] beat_index(input logic [63:0] addr,
                                             input logic [31:0] cnt,
                                             input int          step_log2,
                                             input int          mem_bits);
    return 32'(((addr >> step_log2) + 64'(cnt)) & ((64'd1 << mem_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/ddr_burst_responder_if.sv
// rtl/ddr_burst_responder_if.sv - burst request/finish bus between the cache side and the responder
interface ddr_burst_responder_if
  import ddr_burst_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 28,
  parameter int LEN_W  = BURST_LEN_W
);

  logic              rd_burst_req;
  logic              wr_burst_req;
  logic [LEN_W-1:0]  rd_burst_len;
  logic [LEN_W-1:0]  wr_burst_len;
  logic [ADDR_W-1:0] rd_burst_addr;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic [DATA_W-1:0] wr_burst_data;
  logic              rd_burst_data_valid;
  logic [DATA_W-1:0] rd_burst_data;
  logic              wr_burst_data_req;
  logic              rd_burst_finish;
  logic              wr_burst_finish;
  logic              busy;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  rd_burst_data_valid, rd_burst_data, wr_burst_data_req,
           rd_burst_finish, wr_burst_finish, busy
  );

  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output rd_burst_data_valid, rd_burst_data, wr_burst_data_req,
           rd_burst_finish, wr_burst_finish, busy
  );

endinterface

// File: rtl/ddr_burst_mem.sv
// rtl/ddr_burst_mem.sv - simple dual-port synchronous RAM, one write and one read port, 1-cycle read
module ddr_burst_mem #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddr_burst_responder.sv
// rtl/ddr_burst_responder.sv - serves read/write bursts from on-chip RAM with fixed strobe timing
module ddr_burst_responder
  import ddr_burst_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_ADDR_BITS  = 10,
  parameter int RD_LATENCY     = 2,
  parameter int ADDR_STEP_LOG2 = ADDR_STEP_LOG2_DEF
) (
  input logic                  mem_clk,
  input logic                  rst_n,
  ddr_burst_responder_if.slave bus
);

  localparam logic [15:0] WAIT_LAST = 16'(RD_LATENCY - 1);

  burst_state_e              state;
  logic [BURST_LEN_W-1:0]    burst_len;
  logic [DDR_ADDR_WIDTH-1:0] burst_addr;
  logic [BURST_LEN_W-1:0]    beat_cnt;
  logic [BURST_LEN_W-1:0]    issue_cnt;
  logic [15:0]               wait_cnt;
  logic                      cap_pending;
  logic                      wr_req_q;
  logic                      rd_valid_q;
  logic                      wr_fin_q;
  logic                      rd_fin_q;
  logic                      busy_q;

  logic [MEM_ADDR_BITS-1:0]  wr_idx;
  logic [MEM_ADDR_BITS-1:0]  rd_idx;
  logic [DDR_DATA_WIDTH-1:0] mem_q;

  // Writes land at the captured-beat index; reads run one beat ahead via issue_cnt.
  assign wr_idx = MEM_ADDR_BITS'(beat_index(64'(burst_addr), 32'(beat_cnt),
                                            ADDR_STEP_LOG2, MEM_ADDR_BITS));
  assign rd_idx = MEM_ADDR_BITS'(beat_index(64'(burst_addr), 32'(issue_cnt),
                                            ADDR_STEP_LOG2, MEM_ADDR_BITS));

  ddr_burst_mem #(
    .DATA_W (DDR_DATA_WIDTH),
    .ADDR_W (MEM_ADDR_BITS)
  ) u_mem (
    .clk   (mem_clk),
    .we    (cap_pending),
    .waddr (wr_idx),
    .wdata (bus.wr_burst_data),
    .raddr (rd_idx),
    .rdata (mem_q)
  );

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_len   <= '0;
      burst_addr  <= '0;
      beat_cnt    <= '0;
      issue_cnt   <= '0;
      wait_cnt    <= '0;
      cap_pending <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_fin_q    <= 1'b0;
      rd_fin_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Write data arrives one cycle after each request, so capture trails WR_BEAT by one.
      cap_pending <= (state == WR_BEAT);
      case (state)
        IDLE: begin
          beat_cnt  <= '0;
          issue_cnt <= '0;
          wait_cnt  <= '0;
          if (bus.wr_burst_req) begin
            burst_len  <= bus.wr_burst_len;
            burst_addr <= bus.wr_burst_addr;
            busy_q     <= 1'b1;
            if (bus.wr_burst_len == '0) begin
              state    <= DONE_WR;
              wr_fin_q <= 1'b1;
            end else begin
              state    <= WR_BEAT;
              wr_req_q <= 1'b1;
            end
          end else if (bus.rd_burst_req) begin
            burst_len  <= bus.rd_burst_len;
            burst_addr <= bus.rd_burst_addr;
            busy_q     <= 1'b1;
            if (bus.rd_burst_len == '0) begin
              state    <= DONE_RD;
              rd_fin_q <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        WR_BEAT: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (cap_pending) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (issue_cnt == burst_len - 1'b1) begin
            state    <= WR_LAST;
            wr_req_q <= 1'b0;
          end
        end
        WR_LAST: begin
          state    <= DONE_WR;
          wr_fin_q <= 1'b1;
        end
        RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state      <= RD_BEAT;
            rd_valid_q <= 1'b1;
            issue_cnt  <= issue_cnt + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD_BEAT: begin
          issue_cnt <= issue_cnt + 1'b1;
          beat_cnt  <= beat_cnt + 1'b1;
          if (beat_cnt == burst_len - 1'b1) begin
            state      <= DONE_RD;
            rd_valid_q <= 1'b0;
            rd_fin_q   <= 1'b1;
          end
        end
        DONE_WR: begin
          state    <= IDLE;
          wr_fin_q <= 1'b0;
          busy_q   <= 1'b0;
        end
        DONE_RD: begin
          state    <= IDLE;
          rd_fin_q <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_burst_data_req   = wr_req_q;
  assign bus.rd_burst_data_valid = rd_valid_q;
  assign bus.rd_burst_data       = rd_valid_q ? mem_q : '0;
  assign bus.wr_burst_finish     = wr_fin_q;
  assign bus.rd_burst_finish     = rd_fin_q;
  assign bus.busy                = busy_q;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb/tb_ddr_burst_responder.sv - randomized self-checking bench against a cycle-rule reference model
module tb_ddr_burst_responder;

  localparam int DW     = 128;
  localparam int AW     = 28;
  localparam int MB     = 10;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << MB;

  logic mem_clk;
  logic rst_n;

  ddr_burst_responder_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(10)) bus ();

  ddr_burst_responder #(
    .DDR_DATA_WIDTH (DW),
    .DDR_ADDR_WIDTH (AW),
    .MEM_ADDR_BITS  (MB),
    .RD_LATENCY     (RD_LAT),
    .ADDR_STEP_LOG2 (3)
  ) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            written [DEPTH];
  logic [DW-1:0] wbuf    [128];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int ram_idx(input logic [AW-1:0] addr, input int beat);
    return ((int'(addr) / 8) + beat) % DEPTH;
  endfunction

  // Starts at the beginning of cycle 0 (DUT in IDLE); returns at the start of the cycle after finish.
  task automatic run_burst(input bit is_wr, input logic [AW-1:0] addr, input int len, input int abort_at);
    int  fin;
    bit  aborted;
    bit  exp_req, exp_v, exp_wf, exp_rf, exp_busy;
    int  idx;
    fin     = (len == 0) ? 1 : (is_wr ? len + 2 : RD_LAT + len + 1);
    aborted = 1'b0;
    if (is_wr) begin
      bus.wr_burst_req  = 1'b1;
      bus.wr_burst_addr = addr;
      bus.wr_burst_len  = 10'(len);
    end else begin
      bus.rd_burst_req  = 1'b1;
      bus.rd_burst_addr = addr;
      bus.rd_burst_len  = 10'(len);
    end
    for (int c = 0; c <= fin; c++) begin
      if (c == 1) begin
        if (is_wr) begin
          bus.wr_burst_req  = 1'b0;
          bus.wr_burst_addr = AW'($urandom);
          bus.wr_burst_len  = 10'($urandom);
        end else begin
          bus.rd_burst_req  = 1'b0;
          bus.rd_burst_addr = AW'($urandom);
          bus.rd_burst_len  = 10'($urandom);
        end
      end
      if (is_wr && c >= 2 && c <= len + 1) bus.wr_burst_data = wbuf[c-2];
      else                                 bus.wr_burst_data = rand_word();
      if (abort_at > 0 && c == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        aborted = 1'b1;
        check_eq("abort_valid_async", DW'(bus.rd_burst_data_valid), '0);
        check_eq("abort_data_async", bus.rd_burst_data, '0);
      end
      @(negedge mem_clk);
      if (aborted) rst_n = 1'b1;
      exp_req  = !aborted && is_wr && c >= 1 && c <= len;
      exp_v    = !aborted && !is_wr && len > 0 && c >= RD_LAT + 1 && c <= RD_LAT + len;
      exp_wf   = !aborted && is_wr && c == fin;
      exp_rf   = !aborted && !is_wr && c == fin;
      exp_busy = !aborted && c >= 1;
      check_eq("wr_data_req", DW'(bus.wr_burst_data_req), DW'(exp_req));
      check_eq("rd_valid", DW'(bus.rd_burst_data_valid), DW'(exp_v));
      check_eq("wr_finish", DW'(bus.wr_burst_finish), DW'(exp_wf));
      check_eq("rd_finish", DW'(bus.rd_burst_finish), DW'(exp_rf));
      check_eq("busy", DW'(bus.busy), DW'(exp_busy));
      if (exp_v) begin
        idx = ram_idx(addr, c - RD_LAT - 1);
        if (written[idx]) check_eq("rd_data", bus.rd_burst_data, ref_mem[idx]);
      end else begin
        check_eq("rd_data_idle_zero", bus.rd_burst_data, '0);
      end
      if (is_wr && !aborted && c >= 2 && c <= len + 1) begin
        idx          = ram_idx(addr, c - 2);
        ref_mem[idx] = wbuf[c-2];
        written[idx] = 1'b1;
      end
      @(posedge mem_clk);
      #1;
    end
  endtask

  initial begin
    int len;
    int rlen;
    logic [AW-1:0] addr;

    rst_n             = 1'b0;
    bus.rd_burst_req  = 1'b0;
    bus.wr_burst_req  = 1'b0;
    bus.rd_burst_len  = '0;
    bus.wr_burst_len  = '0;
    bus.rd_burst_addr = '0;
    bus.wr_burst_addr = '0;
    bus.wr_burst_data = '0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    check_eq("reset_wr_req", DW'(bus.wr_burst_data_req), '0);
    check_eq("reset_rd_valid", DW'(bus.rd_burst_data_valid), '0);
    check_eq("reset_rd_data", bus.rd_burst_data, '0);
    check_eq("reset_finish", DW'({bus.wr_burst_finish, bus.rd_burst_finish}), '0);
    check_eq("reset_busy", DW'(bus.busy), '0);
    rst_n = 1'b1;
    @(posedge mem_clk);
    #1;

    // Write then read back A..D at 0
    wbuf[0] = 'hA; wbuf[1] = 'hB; wbuf[2] = 'hC; wbuf[3] = 'hD;
    run_burst(1'b1, '0, 4, 0);
    run_burst(1'b0, '0, 4, 0);

    // Simultaneous requests: write first, read accepted right after write finish
    for (int i = 0; i < 3; i++) wbuf[i] = rand_word();
    bus.rd_burst_req  = 1'b1;
    bus.rd_burst_addr = 28'h80;
    bus.rd_burst_len  = 10'd3;
    run_burst(1'b1, 28'h80, 3, 0);
    run_burst(1'b0, 28'h80, 3, 0);

    // Zero length
    run_burst(1'b1, 28'h40, 0, 0);
    run_burst(1'b0, 28'h40, 0, 0);

    // Wrap-around through index 0
    wbuf[0] = 'h11; wbuf[1] = 'h22;
    run_burst(1'b1, AW'((DEPTH - 1) * 8), 2, 0);
    run_burst(1'b0, '0, 1, 0);
    run_burst(1'b0, AW'((DEPTH - 1) * 8), 1, 0);
    check_eq("wrap_model_hi", ref_mem[DEPTH-1], DW'('h11));
    check_eq("wrap_model_lo", ref_mem[0], DW'('h22));

    // Reset in the 2nd valid cycle of a len-8 read, then a clean re-read
    for (int i = 0; i < 8; i++) wbuf[i] = rand_word();
    run_burst(1'b1, 28'h400, 8, 0);
    run_burst(1'b0, 28'h400, 8, RD_LAT + 2);
    run_burst(1'b0, 28'h400, 8, 0);

    // Long write 0..64 and read back
    for (int i = 0; i < 65; i++) wbuf[i] = DW'(i);
    run_burst(1'b1, 28'h1000, 65, 0);
    run_burst(1'b0, 28'h1000, 65, 0);

    // Randomized write/read pairs
    for (int it = 0; it < 10; it++) begin
      len  = $urandom_range(0, 12);
      rlen = $urandom_range(0, 14);
      addr = AW'($urandom);
      for (int i = 0; i < len; i++) wbuf[i] = rand_word();
      run_burst(1'b1, addr, len, 0);
      run_burst(1'b0, addr, rlen, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
